// File: rtl/mips_cpu_pc_sequencer.sv
// Program-counter sequencer for the MIPS CPU.
// Owns the fetch address and applies branch, jump-immediate and
// jump-register redirects, with an optional single branch delay slot.
// The CPU halts when the PC is loaded with HALT_ADDR. A misaligned target,
// or a redirect issued from a delay slot, sets a sticky fault flag.
module mips_cpu_pc_sequencer #(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000,
  parameter int          DELAY_SLOTS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_kind,
  input  logic [15:0]       branch_offset,
  input  logic [25:0]       jump_index,
  input  logic [ADDR_W-1:0] jump_reg,
  output logic [ADDR_W-1:0] instr_address,
  output logic [ADDR_W-1:0] link_address,
  output logic              in_delay_slot,
  output logic              active,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] HALT_PC  = ADDR_W'(HALT_ADDR);

  localparam logic [1:0] KIND_BRANCH = 2'd0;
  localparam logic [1:0] KIND_JIMM   = 2'd1;
  localparam logic [1:0] KIND_JREG   = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DELAY  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] target_reg, target_next;
  logic              fault_reg, fault_next;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] pc_plus8;
  logic [ADDR_W-1:0] branch_disp;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] redirect_target;
  logic              redirect_req;
  logic              target_aligned;

  assign pc_plus4      = pc_reg + ADDR_W'(4);
  assign pc_plus8      = pc_reg + ADDR_W'(8);
  assign branch_disp   = {{(ADDR_W-18){branch_offset[15]}}, branch_offset, 2'b00};
  assign branch_target = pc_plus4 + branch_disp;

  // The jump-immediate target keeps the upper PC bits from the delay-slot address.
  // When ADDR_W is exactly 28 there are no upper bits to keep.
  generate
    if (ADDR_W > 28) begin : g_jump_hi
      assign jump_target = {pc_plus4[ADDR_W-1:28], jump_index, 2'b00};
    end else begin : g_jump_nohi
      assign jump_target = {jump_index, 2'b00};
    end
  endgenerate

  // The link address points past the delay slot when a delay slot is present.
  assign link_address = (DELAY_SLOTS != 0) ? pc_plus8 : pc_plus4;

  // Redirect kind 3 is reserved and never counts as a redirect.
  assign redirect_req   = redirect_valid && (redirect_kind != 2'd3);
  assign target_aligned = (redirect_target[1:0] == 2'b00);

  // Select the redirect target for the requested kind.
  always_comb begin
    redirect_target = branch_target;
    case (redirect_kind)
      KIND_BRANCH: redirect_target = branch_target;
      KIND_JIMM:   redirect_target = jump_target;
      KIND_JREG:   redirect_target = jump_reg;
      default:     redirect_target = branch_target;
    endcase
  end

  // State register: PC, FSM state, pending target and sticky fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_RUN;
      pc_reg     <= RESET_PC;
      target_reg <= '0;
      fault_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      target_reg <= target_next;
      fault_reg  <= fault_next;
    end
  end

  // Next-state logic. A stall holds everything. Loading HALT_PC halts the CPU,
  // whichever path produced that value.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    target_next = target_reg;
    fault_next  = fault_reg;
    if (clk_enable) begin
      case (state_reg)
        ST_RUN: begin
          pc_next = pc_plus4;
          if (redirect_req) begin
            if (!target_aligned) begin
              fault_next = 1'b1;
            end else if (DELAY_SLOTS != 0) begin
              target_next = redirect_target;
              state_next  = ST_DELAY;
            end else begin
              pc_next = redirect_target;
            end
          end
          if (pc_next == HALT_PC) state_next = ST_HALTED;
        end
        ST_DELAY: begin
          pc_next    = target_reg;
          state_next = ST_RUN;
          if (redirect_req) fault_next = 1'b1;
          if (pc_next == HALT_PC) state_next = ST_HALTED;
        end
        default: begin
          state_next = ST_HALTED;
        end
      endcase
    end
  end

  // Output decode from the registered state.
  always_comb begin
    instr_address = pc_reg;
    in_delay_slot = (state_reg == ST_DELAY);
    active        = (state_reg != ST_HALTED);
    fault         = fault_reg;
  end

endmodule

// File: tb/tb_mips_cpu_pc_sequencer.sv
// Scoreboard bench for mips_cpu_pc_sequencer. Two builds are instantiated:
// one with a delay slot and one without. The stimulus pushes the expected
// state after each clock edge; the monitor pops and compares on the falling edge.
module tb_mips_cpu_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        redirect_valid;
  logic [1:0]  redirect_kind;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] jump_reg;

  logic [31:0] ia1, la1, ia0, la0;
  logic        ds1, ac1, fl1, ds0, ac0, fl0;

  always #5 clk = ~clk;

  mips_cpu_pc_sequencer #(.DELAY_SLOTS(1)) u_ds1 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .redirect_valid(redirect_valid), .redirect_kind(redirect_kind),
    .branch_offset(branch_offset), .jump_index(jump_index), .jump_reg(jump_reg),
    .instr_address(ia1), .link_address(la1), .in_delay_slot(ds1),
    .active(ac1), .fault(fl1)
  );

  mips_cpu_pc_sequencer #(.DELAY_SLOTS(0)) u_ds0 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .redirect_valid(redirect_valid), .redirect_kind(redirect_kind),
    .branch_offset(branch_offset), .jump_index(jump_index), .jump_reg(jump_reg),
    .instr_address(ia0), .link_address(la0), .in_delay_slot(ds0),
    .active(ac0), .fault(fl0)
  );

  typedef struct {
    int          tag;
    int          dut;
    logic [31:0] pc;
    logic [31:0] link;
    logic        ds;
    logic        act;
    logic        flt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cur_dut = 1;
  int   tag_cnt = 0;

  // Monitor: compare the selected build's outputs against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      logic [31:0] a_pc, a_link;
      logic        a_ds, a_act, a_flt;
      e = exp_q.pop_front();
      if (e.dut == 1) begin
        a_pc = ia1; a_link = la1; a_ds = ds1; a_act = ac1; a_flt = fl1;
      end else begin
        a_pc = ia0; a_link = la0; a_ds = ds0; a_act = ac0; a_flt = fl0;
      end
      n_vec = n_vec + 1;
      if (a_pc !== e.pc || a_link !== e.link || a_ds !== e.ds ||
          a_act !== e.act || a_flt !== e.flt) begin
        n_miss = n_miss + 1;
        $display("FAIL vec%0d ds%0d: got pc=%h link=%h dslot=%b active=%b fault=%b, want pc=%h link=%h dslot=%b active=%b fault=%b",
                 e.tag, e.dut, a_pc, a_link, a_ds, a_act, a_flt,
                 e.pc, e.link, e.ds, e.act, e.flt);
      end else begin
        $display("vec%0d ds%0d: pc=%h link=%h dslot=%b active=%b fault=%b ok",
                 e.tag, e.dut, a_pc, a_link, a_ds, a_act, a_flt);
      end
    end
  end

  // Drive one set of inputs and advance one clock edge.
  task automatic cyc(input logic en, input logic rst, input logic rv,
                     input logic [1:0] kind, input logic [15:0] off,
                     input logic [25:0] idx, input logic [31:0] jr);
    clk_enable     = en;
    reset          = rst;
    redirect_valid = rv;
    redirect_kind  = kind;
    branch_offset  = off;
    jump_index     = idx;
    jump_reg       = jr;
    @(posedge clk);
    #1;
  endtask

  // Push the expected post-edge state. The link address follows from the PC.
  task automatic expect_state(input logic [31:0] pc, input logic ds,
                              input logic act, input logic flt);
    exp_t e;
    e.tag  = tag_cnt;
    e.dut  = cur_dut;
    e.pc   = pc;
    e.link = pc + ((cur_dut == 1) ? 32'd8 : 32'd4);
    e.ds   = ds;
    e.act  = act;
    e.flt  = flt;
    exp_q.push_back(e);
    tag_cnt = tag_cnt + 1;
  endtask

  task automatic idle(input logic [31:0] pc, input logic ds, input logic act, input logic flt);
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0);
    expect_state(pc, ds, act, flt);
  endtask

  initial begin
    // Build with a delay slot.
    cur_dut = 1;
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0);   expect_state(32'hBFC00000, 0, 1, 0);
    idle(32'hBFC00004, 0, 1, 0);
    idle(32'hBFC00008, 0, 1, 0);
    idle(32'hBFC0000C, 0, 1, 0);
    idle(32'hBFC00010, 0, 1, 0);
    // Backward branch: BFC00014 - 16 = BFC00004, reached after the delay slot.
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 16'hFFFC, 26'h0, 32'h0); expect_state(32'hBFC00014, 1, 1, 0);
    idle(32'hBFC00004, 0, 1, 0);
    // Forward branch: BFC00008 + 16 = BFC00018.
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 16'h0004, 26'h0, 32'h0); expect_state(32'hBFC00008, 1, 1, 0);
    // Stall in the delay slot while a redirect is offered: state holds, no fault.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 2'd2, 16'h0, 26'h0, 32'h0);  expect_state(32'hBFC00008, 1, 1, 0);
    end
    // A redirect during the delay slot sets the fault; the latched target still wins.
    cyc(1'b1, 1'b0, 1'b1, 2'd1, 16'h0, 26'h0, 32'h0);    expect_state(32'hBFC00018, 0, 1, 1);
    // Reserved kind is treated as no redirect.
    cyc(1'b1, 1'b0, 1'b1, 2'd3, 16'h0, 26'h0, 32'h0);    expect_state(32'hBFC0001C, 0, 1, 1);
    // Reset clears the fault; a misaligned JR faults and falls through.
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0);    expect_state(32'hBFC00000, 0, 1, 0);
    cyc(1'b1, 1'b0, 1'b1, 2'd2, 16'h0, 26'h0, 32'hBFC00102); expect_state(32'hBFC00004, 0, 1, 1);
    // Reset during the delay slot discards the pending target.
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0);    expect_state(32'hBFC00000, 0, 1, 0);
    cyc(1'b1, 1'b0, 1'b1, 2'd2, 16'h0, 26'h0, 32'hBFC00100); expect_state(32'hBFC00004, 1, 1, 0);
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0);    expect_state(32'hBFC00000, 0, 1, 0);
    idle(32'hBFC00004, 0, 1, 0);
    // JR to address 0: the delay slot executes, then the CPU halts.
    cyc(1'b1, 1'b0, 1'b1, 2'd2, 16'h0, 26'h0, 32'h0);    expect_state(32'hBFC00008, 1, 1, 0);
    idle(32'h00000000, 0, 0, 0);
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 16'h0004, 26'h0, 32'h0); expect_state(32'h00000000, 0, 0, 0);
    cyc(1'b1, 1'b0, 1'b1, 2'd2, 16'h0, 26'h0, 32'hBFC00100); expect_state(32'h00000000, 0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0);    expect_state(32'hBFC00000, 0, 1, 0);

    // Build without a delay slot. Reset is applied during a stall.
    cur_dut = 0;
    cyc(1'b0, 1'b1, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0);    expect_state(32'hBFC00000, 0, 1, 0);
    // J with index 0x10: the upper nibble B comes from PC+4, giving B0000040.
    cyc(1'b1, 1'b0, 1'b1, 2'd1, 16'h0, 26'h0000010, 32'h0); expect_state(32'hB0000040, 0, 1, 0);
    idle(32'hB0000044, 0, 1, 0);
    // Branch offset -1: B0000048 - 4 = B0000044.
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 16'hFFFF, 26'h0, 32'h0); expect_state(32'hB0000044, 0, 1, 0);
    // JR to the top word, then PC+4 wraps to 0 and halts.
    cyc(1'b1, 1'b0, 1'b1, 2'd2, 16'h0, 26'h0, 32'hFFFFFFFC); expect_state(32'hFFFFFFFC, 0, 1, 0);
    idle(32'h00000000, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0);    expect_state(32'hBFC00000, 0, 1, 0);
    cyc(1'b1, 1'b0, 1'b1, 2'd2, 16'h0, 26'h0, 32'h00000002); expect_state(32'hBFC00004, 0, 1, 1);

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_miss = n_miss + 1;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
